// File: rtl/song_sequencer.sv
// Song sequencer: walks one song in the synchronous song ROM and hands each
// non-sentinel word to the note arranger over a load/done handshake.
module song_sequencer #(
  parameter int unsigned SONG_BITS = 2,
  parameter int unsigned IDX_BITS  = 5,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [15:0]                   rom_data,
  output logic [15:0]                   note_to_load,
  output logic                          load_new_note,
  input  logic                          note_done,
  output logic                          song_playing,
  output logic                          song_done,
  output logic                          error
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [SONG_BITS-1:0] song_q;
  logic [IDX_BITS-1:0]  idx_q;
  logic [IDX_BITS-1:0]  idx_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [15:0]          note_q;
  logic                 load_q;
  logic                 playing_q;
  logic                 done_q;
  logic                 error_q;
  logic                 idx_last;
  logic                 timeout_hit;

  assign idx_d       = idx_q + IDX_BITS'(1);
  assign cnt_d       = cnt_q + CNT_W'(1);
  assign idx_last    = &idx_q;
  assign timeout_hit = (cnt_d == CNT_W'(TIMEOUT));

  // Sequencer FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      song_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      note_q    <= '0;
      load_q    <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (play) begin
            song_q    <= song;
            idx_q     <= '0;
            playing_q <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_PRESENT;
        end
        S_PRESENT: begin
          // An all-zero word marks the end of the song
          if (rom_data == 16'h0000) begin
            playing_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            note_q  <= rom_data;
            load_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (note_done) begin
            if (idx_last) begin
              playing_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              idx_q   <= idx_d;
              state_q <= play ? S_FETCH : S_HOLD;
            end
          end else if (timeout_hit) begin
            error_q   <= 1'b1;
            playing_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_HOLD: begin
          if (play) begin
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          // Requiring play to drop here prevents an automatic restart
          if (!play) begin
            error_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          playing_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr      = {song_q, idx_q};
  assign note_to_load  = note_q;
  assign load_new_note = load_q;
  assign song_playing  = playing_q;
  assign song_done     = done_q;
  assign error         = error_q;

endmodule
